// File: rtl/alarm_bank_pkg.sv
// alarm_bank_pkg: shared types and constants for the alarm bank
package alarm_bank_pkg;
    localparam int SEC_PER_DAY = 86400;
    localparam int SOD_W = 17;
    localparam int CNT_W = 16;
    localparam int SNZ_W = 8;
    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZED} alarm_state_t;
    typedef struct packed {
        logic [SOD_W-1:0] sod;
        logic en;
        logic rpt;
        alarm_state_t state;
        logic [CNT_W-1:0] ring_cnt;
        logic [SNZ_W-1:0] snz_cnt;
    } alarm_chan_t;
endpackage

// File: rtl/alarm_bank_ctrl_posix_to_sod.sv
// posix_to_sod: GMT-shifted POSIX time reduced mod 86400 by a bit-serial restoring divider
module posix_to_sod
    import alarm_bank_pkg::*;
#(
    parameter int GMT = 3
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      cur_posix_time_i,
    input  logic             tick_i,
    output logic             sod_valid_o,
    output logic [SOD_W-1:0] sod_o
);
    logic signed [33:0] v;
    logic [32:0] u;
    logic [SOD_W:0] t;
    logic [SOD_W-1:0] rem, rem_nxt;
    logic [31:0] q;
    logic [4:0] cnt;
    logic busy;
    assign v = $signed({2'b00, cur_posix_time_i}) + 34'(GMT * 3600);
    assign u = v[33] ? 33'(v + 34'sd86400) : v[32:0];
    assign t = {rem, q[31]};
    assign rem_nxt = t >= (SOD_W+1)'(SEC_PER_DAY) ? SOD_W'(t - (SOD_W+1)'(SEC_PER_DAY)) : t[SOD_W-1:0];
    assign sod_o = rem;
    // bit 32 seeds the remainder so 32 iterations cover the full 33-bit value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy <= 1'b0;
            cnt <= '0;
            rem <= '0;
            q <= '0;
            sod_valid_o <= 1'b0;
        end else begin
            sod_valid_o <= 1'b0;
            if (tick_i) begin
                busy <= 1'b1;
                cnt <= '0;
                rem <= SOD_W'(u[32]);
                q <= u[31:0];
            end else if (busy) begin
                rem <= rem_nxt;
                q <= {q[30:0], 1'b0};
                cnt <= cnt + 5'd1;
                busy <= cnt != 5'd31;
                sod_valid_o <= cnt == 5'd31;
            end
        end
    end
endmodule

// File: rtl/alarm_bank_ctrl.sv
// alarm_bank_ctrl: N-channel alarm bank with snooze, daily repeat and priority readout
module alarm_bank_ctrl
    import alarm_bank_pkg::*;
#(
    parameter int ALARMS_CNT = 7,
    parameter int GMT = 3,
    parameter int RING_TIME_SEC = 10,
    parameter int SNOOZE_TIME_SEC = 5,
    parameter int MAX_SNOOZE = 3,
    parameter int IDX_W = (ALARMS_CNT > 1) ? $clog2(ALARMS_CNT) : 1
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           cur_posix_time_i,
    input  logic                  tick_i,
    input  logic                  cfg_we_i,
    input  logic [IDX_W-1:0]      cfg_idx_i,
    input  logic [SOD_W-1:0]      cfg_sod_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_repeat_i,
    input  logic                  off_stb_i,
    input  logic                  snooze_stb_i,
    output logic [ALARMS_CNT-1:0] alarm_o,
    output logic                  active_valid_o,
    output logic [IDX_W-1:0]      active_idx_o,
    output logic                  cfg_err_o
);
    logic sec;
    logic [SOD_W-1:0] sod;
    logic cfg_ok;
    logic [ALARMS_CNT-1:0] ring_nxt, act_nxt;
    logic [IDX_W-1:0] idx_nxt;
    posix_to_sod #(.GMT(GMT)) u_sod (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .cur_posix_time_i(cur_posix_time_i),
        .tick_i(tick_i),
        .sod_valid_o(sec),
        .sod_o(sod)
    );
    assign cfg_ok = 32'(cfg_idx_i) < ALARMS_CNT && 32'(cfg_sod_i) < SEC_PER_DAY;
    for (genvar i = 0; i < ALARMS_CNT; i++) begin : gen_ch
        alarm_chan_t ch, nx;
        logic fin, wr;
        assign wr = cfg_we_i && cfg_ok && 32'(cfg_idx_i) == i;
        // priority: config write, then off/snooze strobes, then the second event
        always_comb begin
            nx = ch;
            fin = 1'b0;
            if (wr) begin
                nx.sod = cfg_sod_i;
                nx.en = cfg_en_i;
                nx.rpt = cfg_repeat_i;
                nx.state = cfg_en_i ? ARMED : IDLE;
                nx.ring_cnt = '0;
                nx.snz_cnt = '0;
            end else begin
                case (ch.state)
                    ARMED: if (sec && sod == ch.sod) begin
                        nx.state = RINGING;
                        nx.ring_cnt = CNT_W'(RING_TIME_SEC);
                        nx.snz_cnt = '0;
                    end
                    RINGING: if (off_stb_i || (snooze_stb_i && ch.snz_cnt >= SNZ_W'(MAX_SNOOZE))) begin
                        fin = 1'b1;
                    end else if (snooze_stb_i) begin
                        nx.state = SNOOZED;
                        nx.ring_cnt = CNT_W'(SNOOZE_TIME_SEC);
                        nx.snz_cnt = ch.snz_cnt + SNZ_W'(1);
                    end else if (sec) begin
                        fin = ch.ring_cnt <= CNT_W'(1);
                        nx.ring_cnt = ch.ring_cnt - CNT_W'(1);
                    end
                    SNOOZED: if (off_stb_i) begin
                        fin = 1'b1;
                    end else if (sec) begin
                        nx.state = ch.ring_cnt <= CNT_W'(1) ? RINGING : SNOOZED;
                        nx.ring_cnt = ch.ring_cnt <= CNT_W'(1) ? CNT_W'(RING_TIME_SEC) : ch.ring_cnt - CNT_W'(1);
                    end
                    default: ;
                endcase
                if (fin) begin
                    nx.state = ch.rpt ? ARMED : IDLE;
                    nx.en = ch.rpt;
                    nx.ring_cnt = '0;
                    nx.snz_cnt = '0;
                end
            end
        end
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) ch <= '0;
            else ch <= nx;
        end
        assign ring_nxt[i] = nx.state == RINGING;
        assign act_nxt[i] = nx.state == RINGING || nx.state == SNOOZED;
    end
    always_comb begin
        idx_nxt = '0;
        for (int k = ALARMS_CNT - 1; k >= 0; k--) if (act_nxt[k]) idx_nxt = IDX_W'(k);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alarm_o <= '0;
            active_valid_o <= 1'b0;
            active_idx_o <= '0;
            cfg_err_o <= 1'b0;
        end else begin
            alarm_o <= ring_nxt;
            active_valid_o <= |act_nxt;
            active_idx_o <= idx_nxt;
            cfg_err_o <= cfg_we_i && !cfg_ok;
        end
    end
endmodule

// File: tb/tb_alarm_bank_ctrl.sv
// tb_alarm_bank_ctrl: scoreboard bench for alarm_bank_ctrl (main GMT=+3 instance, GMT=-3 companion)
module tb_alarm_bank_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] posix = '0;
    logic tick = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0, cfg_rpt = 1'b0, off_stb = 1'b0, snz_stb = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic [16:0] cfg_sod = '0;
    logic [6:0] alarm, n_alarm;
    logic valid, n_valid, err, n_err;
    logic [2:0] idx, n_idx;
    int total = 0, bad = 0, cyc = 0, p;
    typedef struct {
        int due;
        logic [6:0] a;
        logic v;
        logic [2:0] i;
        logic e;
        string tag;
    } exp_t;
    exp_t sb[$];
    exp_t cur;
    logic [6:0] pa = '0;
    logic pv = 1'b0;
    logic [2:0] pi = '0;

    alarm_bank_ctrl dut (
        .clk_i(clk), .rst_i(rst), .cur_posix_time_i(posix), .tick_i(tick),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_sod_i(cfg_sod), .cfg_en_i(cfg_en),
        .cfg_repeat_i(cfg_rpt), .off_stb_i(off_stb), .snooze_stb_i(snz_stb),
        .alarm_o(alarm), .active_valid_o(valid), .active_idx_o(idx), .cfg_err_o(err)
    );
    alarm_bank_ctrl #(.GMT(-3)) u_neg (
        .clk_i(clk), .rst_i(rst), .cur_posix_time_i(posix), .tick_i(tick),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_sod_i(cfg_sod), .cfg_en_i(cfg_en),
        .cfg_repeat_i(cfg_rpt), .off_stb_i(off_stb), .snooze_stb_i(snz_stb),
        .alarm_o(n_alarm), .active_valid_o(n_valid), .active_idx_o(n_idx), .cfg_err_o(n_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due == cyc) begin
            cur = sb.pop_front();
            chk({cur.tag, "_alarm"}, 32'(alarm), 32'(cur.a));
            chk({cur.tag, "_valid"}, 32'(valid), 32'(cur.v));
            chk({cur.tag, "_idx"}, 32'(idx), 32'(cur.i));
            chk({cur.tag, "_err"}, 32'(err), 32'(cur.e));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [6:0] a, input logic v, input logic [2:0] i, input logic e, input string tag);
        exp_t x;
        x.due = cyc + d;
        x.a = a;
        x.v = v;
        x.i = i;
        x.e = e;
        x.tag = tag;
        sb.push_back(x);
    endtask

    // old value one cycle before the expected change, new value at it, err back low after
    task automatic expect_new(input int lat, input logic [6:0] a, input logic v, input logic [2:0] i, input logic e, input string tag);
        push(lat - 1, pa, pv, pi, 1'b0, {tag, "_pre"});
        push(lat, a, v, i, e, tag);
        push(lat + 1, a, v, i, 1'b0, {tag, "_post"});
        pa = a;
        pv = v;
        pi = i;
    endtask

    task automatic sec(input int t, input logic [6:0] a, input logic v, input logic [2:0] i, input string tag);
        step();
        posix = 32'(t);
        tick = 1'b1;
        expect_new(34, a, v, i, 1'b0, tag);
        step();
        tick = 1'b0;
        repeat (35) step();
    endtask

    task automatic sec_same(input int t, input string tag);
        sec(t, pa, pv, pi, tag);
    endtask

    task automatic strobe(input logic o, input logic s, input logic [6:0] a, input logic v, input logic [2:0] i, input string tag);
        step();
        off_stb = o;
        snz_stb = s;
        expect_new(1, a, v, i, 1'b0, tag);
        step();
        off_stb = 1'b0;
        snz_stb = 1'b0;
        step();
    endtask

    task automatic write_cfg(input logic [2:0] ci, input int s, input logic en, input logic r, input logic e,
                             input logic [6:0] a, input logic v, input logic [2:0] i, input string tag);
        step();
        cfg_idx = ci;
        cfg_sod = 17'(s);
        cfg_en = en;
        cfg_rpt = r;
        cfg_we = 1'b1;
        expect_new(1, a, v, i, e, tag);
        step();
        cfg_we = 1'b0;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        // basic match and 10-second timeout of a one-shot channel
        write_cfg(3'd2, 25200, 1'b1, 1'b0, 1'b0, pa, pv, pi, "cfg_ch2");
        sec(14400, 7'h04, 1'b1, 3'd2, "basic_ring");
        for (int k = 1; k <= 9; k++) sec_same(14400 + k, "basic_hold");
        sec(14410, 7'h00, 1'b0, 3'd0, "basic_timeout");
        sec_same(14400, "oneshot_idle");
        // midnight wrap and negative offset
        write_cfg(3'd0, 0, 1'b1, 1'b1, 1'b0, pa, pv, pi, "cfg_ch0");
        write_cfg(3'd6, 75600, 1'b1, 1'b0, 1'b0, pa, pv, pi, "cfg_ch6");
        sec(75600, 7'h01, 1'b1, 3'd0, "midnight");
        strobe(1'b1, 1'b0, 7'h00, 1'b0, 3'd0, "off_ch0");
        sec_same(0, "sod_10800");
        chk("neg_alarm", 32'(n_alarm), 32'h40);
        chk("neg_valid", 32'(n_valid), 1);
        chk("neg_idx", 32'(n_idx), 6);
        chk("neg_err", 32'(n_err), 0);
        strobe(1'b1, 1'b0, pa, pv, pi, "off_neg");
        chk("neg_off", 32'(n_alarm), 0);
        write_cfg(3'd0, 0, 1'b0, 1'b0, 1'b0, pa, pv, pi, "dis_ch0");
        write_cfg(3'd6, 75600, 1'b0, 1'b0, 1'b0, pa, pv, pi, "dis_ch6");
        // snooze limit with daily repeat
        write_cfg(3'd1, 40000, 1'b1, 1'b1, 1'b0, pa, pv, pi, "cfg_ch1");
        sec(29200, 7'h02, 1'b1, 3'd1, "snz_ring");
        p = 29201;
        for (int s = 0; s < 3; s++) begin
            strobe(1'b0, 1'b1, 7'h00, 1'b1, 3'd1, "snooze");
            for (int t = 0; t < 4; t++) begin
                sec_same(p, "snoozed");
                p++;
            end
            sec(p, 7'h02, 1'b1, 3'd1, "rering");
            p++;
        end
        strobe(1'b0, 1'b1, 7'h00, 1'b0, 3'd0, "snooze_excess");
        sec(115600, 7'h02, 1'b1, 3'd1, "next_day");
        strobe(1'b1, 1'b0, 7'h00, 1'b0, 3'd0, "off_ch1");
        // priority and simultaneous strobes
        write_cfg(3'd3, 50000, 1'b1, 1'b0, 1'b0, pa, pv, pi, "cfg_ch3");
        write_cfg(3'd5, 50000, 1'b1, 1'b0, 1'b0, pa, pv, pi, "cfg_ch5");
        sec(39200, 7'h28, 1'b1, 3'd3, "prio");
        strobe(1'b1, 1'b1, 7'h00, 1'b0, 3'd0, "off_and_snooze");
        // invalid writes, then rewrite of a ringing channel
        write_cfg(3'd7, 100, 1'b1, 1'b0, 1'b1, pa, pv, pi, "bad_idx");
        write_cfg(3'd1, 86400, 1'b0, 1'b0, 1'b1, pa, pv, pi, "bad_sod");
        sec(29200, 7'h02, 1'b1, 3'd1, "ch1_kept");
        write_cfg(3'd1, 40000, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 3'd0, "rewrite_ringing");
        // asynchronous reset while ringing
        sec(29200, 7'h02, 1'b1, 3'd1, "ring_again");
        step();
        #2 rst = 1'b1;
        #1;
        chk("abort_alarm", 32'(alarm), 0);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_idx", 32'(idx), 0);
        chk("abort_err", 32'(err), 0);
        pa = '0;
        pv = 1'b0;
        pi = '0;
        step();
        rst = 1'b0;
        // reset while the divider is busy drops its result
        step();
        posix = 32'd76600;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (4) step();
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
        write_cfg(3'd4, 1000, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 3'd0, "cfg_ch4");
        push(35, 7'h00, 1'b0, 3'd0, 1'b0, "div_abort_quiet");
        repeat (36) step();
        // second tick mid-divide restarts the divider
        step();
        posix = 32'd0;
        tick = 1'b1;
        push(34, 7'h00, 1'b0, 3'd0, 1'b0, "first_dropped");
        step();
        tick = 1'b0;
        repeat (8) step();
        step();
        posix = 32'd76600;
        tick = 1'b1;
        expect_new(34, 7'h10, 1'b1, 3'd4, 1'b0, "restart");
        step();
        tick = 1'b0;
        repeat (35) step();
        strobe(1'b1, 1'b0, 7'h00, 1'b0, 3'd0, "final_off");
        repeat (5) step();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alarm_bank_ctrl.md
Name: alarm_bank_ctrl

Overview:
- Parametrised N-channel alarm engine, successor to the fixed per-instance alarm array in the top-level clock.
- Replaces one alarm_clock per channel with a single bank holding per-channel seconds-of-day alarm time, enable, daily-repeat flag and limited snooze count.
- Derives local seconds-of-day from POSIX time once per second.
- Exposes ringing vector plus highest-priority (lowest index) active channel for the display path.

Parameters:
- ALARMS_CNT, 7, number of alarm channels (1..32)
- GMT, 3, signed hour offset added to POSIX time before seconds-of-day extraction
- RING_TIME_SEC, 10, seconds an alarm rings before auto-timeout
- SNOOZE_TIME_SEC, 5, seconds spent in snooze before re-ringing
- MAX_SNOOZE, 3, snoozes allowed per ring episode; the next snooze acts as off
- IDX_W, $clog2(ALARMS_CNT) min 1, channel index width

Ports:
- clk_i  in  1  system clock (50 MHz domain)
- rst_i  in  1  reset, asynchronous, active-high
- cur_posix_time_i  in  32  current POSIX time, stable when tick_i is high
- tick_i  in  1  one-cycle pulse, once per second, when cur_posix_time_i updates
- cfg_we_i  in  1  one-cycle channel configuration write
- cfg_idx_i  in  IDX_W  channel to configure
- cfg_sod_i  in  17  alarm time, seconds of day 0..86399
- cfg_en_i  in  1  channel enable
- cfg_repeat_i  in  1  1 = re-arm daily after episode; 0 = one-shot
- off_stb_i  in  1  user off strobe
- snooze_stb_i  in  1  user snooze strobe
- alarm_o  out  ALARMS_CNT  per-channel ringing (RINGING state only)
- active_valid_o  out  1  any channel RINGING or SNOOZED
- active_idx_o  out  IDX_W  lowest index in RINGING/SNOOZED, 0 if none
- cfg_err_o  out  1  one-cycle pulse on a write with invalid idx or sod

Behaviour:
- Reset: every channel IDLE, time 0, en 0, repeat 0, counters 0. All outputs 0. Divider idle. Reset mid-operation aborts the divider and any ringing immediately.
- SOD extraction (sub-module): on tick_i, load a 33-bit signed value v = posix + GMT*3600.
  - A negative v is corrected by adding 86400.
  - 32-iteration restoring division by 86400, one bit per cycle.
  - sod_valid pulses exactly 33 cycles after tick_i, with sod = v mod 86400.
  - A tick_i arriving while the divider is busy restarts it; the old result is dropped.
- All per-second actions happen on the sod_valid cycle (the "second event"). Outputs change the cycle after it, i.e. tick + 34.
- Per-channel FSM: IDLE, ARMED, RINGING, SNOOZED.
  - ARMED -> RINGING on a second event with sod == alarm time. Load ring_cnt = RING_TIME_SEC and snz_cnt = 0. Exact equality only: a time jump past the alarm does not catch up.
  - RINGING: ring_cnt decrements each second event. When the decrement reaches 0 the episode ends.
  - RINGING + snooze_stb_i:
    - If snz_cnt < MAX_SNOOZE: -> SNOOZED, load wait = SNOOZE_TIME_SEC, increment snz_cnt.
    - Otherwise the snooze is treated as off.
  - SNOOZED: wait decrements each second event. At 0 -> RINGING with ring_cnt reloaded.
  - Episode end (off, timeout or excess snooze): -> ARMED if repeat, else IDLE with en cleared.
- Strobe scope:
  - off_stb_i and snooze_stb_i act on all RINGING channels next cycle.
  - off_stb_i also ends SNOOZED channels; snooze_stb_i ignores them.
  - Simultaneous off and snooze: off wins.
  - A strobe coincident with a second event: the strobe wins for that channel and no decrement applies.
- Config write:
  - Write with cfg_idx_i >= ALARMS_CNT or cfg_sod_i > 86399: ignored, cfg_err_o pulses next cycle.
  - Valid write sets time/en/repeat and forces the state to ARMED (en=1) or IDLE (en=0). Any ring or snooze on that channel is cancelled.
  - A valid write wins over a same-cycle match or strobe on that channel.
- Multiple channels may ring at once. active_idx_o is a registered priority encode, same-cycle as alarm_o.

Decomposition:
- Package alarm_bank_pkg: alarm_state_t enum {IDLE, ARMED, RINGING, SNOOZED}; SEC_PER_DAY = 86400; SOD_W = 17; per-channel record struct (time, en, repeat, state, ring_cnt, snz_cnt).
- Sub-module posix_to_sod: GMT offset plus sequential mod-86400 divider, handshake tick -> sod_valid/sod.
- Channel FSMs live in a generate loop inside alarm_bank_ctrl.

Test Plan:
- Basic match: GMT=3, cfg ch2 sod=25200 en=1 repeat=0; tick at posix 14400 -> alarm_o=0000100 at tick+34, active_idx_o=2; after 10 further ticks -> alarm_o=0, ch2 IDLE.
- Midnight wrap: cfg ch0 sod=0; tick posix 75600 -> ch0 rings. Tick posix 0 -> sod=10800, no ring. GMT=-3 with posix 0 -> sod=75600, negative path exercised.
- Snooze limit: ring ch1, snooze 3 times -> alarm_o[1] low for 5 ticks each time, then re-rings. 4th snooze -> episode ends; repeat=1 leaves ch1 ARMED and it rings again at posix+86400.
- Priority and strobes: ch3 and ch5 same time -> alarm_o=0101000, active_idx_o=3. Off+snooze in the same cycle -> both off next cycle, no SNOOZED.
- Config edge: write idx=7 (N=7) or sod=86400 -> cfg_err_o one pulse, no state change. Rewrite of a ringing channel -> alarm_o bit drops next cycle.
- Reset/abort: assert rst_i while ringing and while the divider is busy -> all outputs 0 immediately. Second tick during divide -> only one sod_valid, 33 cycles after the second tick.
